// File: rtl/minimac2_mdio_slave_if.sv
// Register-file port of the MDIO responder: the responder is the master of this bus.
interface minimac2_mdio_slave_if;
  localparam int unsigned addr_w = 5;
  localparam int unsigned data_w = 16;

  logic [addr_w-1:0] reg_a;
  logic              reg_re;
  logic [data_w-1:0] reg_di;
  logic              reg_we;
  logic [data_w-1:0] reg_do;

  modport master (output reg_a, output reg_re, input reg_di, output reg_we, output reg_do);
  modport slave  (input reg_a, input reg_re, output reg_di, input reg_we, input reg_do);
endinterface

// File: rtl/minimac2_mdio_slave.sv
// Clause-22 MDIO responder, oversampling MDC/MDIO in the sys_clk domain.
// Optional MINIMAC2_MDIO_PREAMBLE_SUPPRESSION_EN: one preamble bit suffices after a matched frame.
module minimac2_mdio_slave #(
  parameter logic [4:0]  phy_addr     = 5'd1,
  parameter int unsigned preamble_len = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  mdc,
  input  logic                  mdio_i,
  output logic                  mdio_o,
  output logic                  mdio_oe,
  output logic                  frame_err,
  minimac2_mdio_slave_if.master regs
);
  localparam int unsigned ones_w = 6;
  localparam int unsigned cnt_w  = 5;
  localparam int unsigned addr_w = 5;
  localparam int unsigned data_w = 16;
  localparam logic [ones_w-1:0] ones_max = ones_w'(32);
  localparam logic [ones_w-1:0] pre_req  = ones_w'(preamble_len);

  typedef enum logic [2:0] {PRE, ST, OP, PHYAD, REGAD, TA, DATA} state_t;

  logic [1:0] mdc_sync, mdio_sync;
  logic       mdc_prev, mdc_rise, sbit;

  state_t            state, state_n;
  logic [ones_w-1:0] ones, ones_n, pre_need;
  logic [cnt_w-1:0]  bit_cnt, cnt_n;
  logic              op_hi, op_hi_n, is_read, is_read_n, match, match_n, re_d;
  logic [addr_w-1:0] addr_sr, addr_n, reg_a_n;
  logic [data_w-1:0] data_sr, data_n, reg_do_n;
  logic              re_n, we_n, err_n, mdio_o_n, mdio_oe_n, bad_c, done_c;
`ifdef MINIMAC2_MDIO_PREAMBLE_SUPPRESSION_EN
  logic              supp, supp_n;
`endif

  // Two-flop synchronisers and MDC edge detect
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      mdc_sync  <= '0;
      mdio_sync <= '0;
      mdc_prev  <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[0], mdc};
      mdio_sync <= {mdio_sync[0], mdio_i};
      mdc_prev  <= mdc_sync[1];
    end
  end

  assign mdc_rise = mdc_sync[1] & ~mdc_prev;
  assign sbit     = mdio_sync[1];

`ifdef MINIMAC2_MDIO_PREAMBLE_SUPPRESSION_EN
  assign pre_need = supp ? ones_w'(1) : pre_req;
`else
  assign pre_need = pre_req;
`endif

  // Frame decoder: next state and registered outputs
  always_comb begin
    state_n   = state;
    ones_n    = ones;
    cnt_n     = bit_cnt;
    op_hi_n   = op_hi;
    is_read_n = is_read;
    match_n   = match;
    addr_n    = addr_sr;
    data_n    = data_sr;
    reg_a_n   = regs.reg_a;
    reg_do_n  = regs.reg_do;
    re_n      = 1'b0;
    we_n      = 1'b0;
    err_n     = 1'b0;
    mdio_o_n  = mdio_o;
    mdio_oe_n = mdio_oe;
    bad_c     = 1'b0;
    done_c    = 1'b0;
`ifdef MINIMAC2_MDIO_PREAMBLE_SUPPRESSION_EN
    supp_n    = supp;
`endif

    if (re_d) data_n = regs.reg_di;

    if (mdc_rise) begin
      case (state)
        PRE: begin
          if (sbit) begin
            ones_n = (ones == ones_max) ? ones : ones + ones_w'(1);
          end else begin
            ones_n = '0;
            if (ones >= pre_need) state_n = ST;
          end
        end
        ST: begin
          if (sbit) begin
            state_n = OP;
            cnt_n   = '0;
          end else begin
            bad_c = 1'b1;
          end
        end
        OP: begin
          if (bit_cnt == cnt_w'(0)) begin
            op_hi_n = sbit;
            cnt_n   = cnt_w'(1);
          end else if (op_hi != sbit) begin
            is_read_n = op_hi;
            state_n   = PHYAD;
            cnt_n     = '0;
          end else begin
            bad_c = 1'b1;
          end
        end
        PHYAD: begin
          addr_n = {addr_sr[addr_w-2:0], sbit};
          cnt_n  = bit_cnt + cnt_w'(1);
          if (bit_cnt == cnt_w'(addr_w - 1)) begin
            match_n = ({addr_sr[addr_w-2:0], sbit} == phy_addr);
            state_n = REGAD;
            cnt_n   = '0;
          end
        end
        REGAD: begin
          addr_n = {addr_sr[addr_w-2:0], sbit};
          cnt_n  = bit_cnt + cnt_w'(1);
          if (bit_cnt == cnt_w'(addr_w - 1)) begin
            reg_a_n = {addr_sr[addr_w-2:0], sbit};
            re_n    = is_read & match;
            state_n = TA;
            cnt_n   = '0;
          end
        end
        TA: begin
          if (bit_cnt == cnt_w'(0)) begin
            cnt_n = cnt_w'(1);
            if (is_read) begin
              if (match) begin
                mdio_oe_n = 1'b1;
                mdio_o_n  = 1'b0;
              end
            end else if (!sbit) begin
              bad_c = 1'b1;
            end
          end else if (is_read || !sbit) begin
            state_n = DATA;
            cnt_n   = '0;
            if (is_read && match) begin
              mdio_o_n = data_sr[data_w-1];
              data_n   = {data_sr[data_w-2:0], 1'b0};
            end
          end else begin
            bad_c = 1'b1;
          end
        end
        DATA: begin
          cnt_n = bit_cnt + cnt_w'(1);
          if (!is_read) data_n = {data_sr[data_w-2:0], sbit};
          if (bit_cnt == cnt_w'(data_w - 1)) begin
            done_c = 1'b1;
            if (is_read) begin
              mdio_oe_n = 1'b0;
              mdio_o_n  = 1'b0;
            end else if (match) begin
              reg_do_n = {data_sr[data_w-2:0], sbit};
              we_n     = 1'b1;
            end
          end else if (is_read && match) begin
            mdio_o_n = data_sr[data_w-1];
            data_n   = {data_sr[data_w-2:0], 1'b0};
          end
        end
        default: state_n = PRE;
      endcase
    end

    // Frame end, good or bad, restarts preamble counting
    if (bad_c || done_c) begin
      state_n = PRE;
      ones_n  = '0;
      cnt_n   = '0;
    end
    if (bad_c) err_n = 1'b1;
`ifdef MINIMAC2_MDIO_PREAMBLE_SUPPRESSION_EN
    if (bad_c) supp_n = 1'b0;
    else if (done_c && match) supp_n = 1'b1;
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= PRE;
      ones        <= '0;
      bit_cnt     <= '0;
      op_hi       <= 1'b0;
      is_read     <= 1'b0;
      match       <= 1'b0;
      addr_sr     <= '0;
      data_sr     <= '0;
      re_d        <= 1'b0;
      regs.reg_a  <= '0;
      regs.reg_do <= '0;
      regs.reg_re <= 1'b0;
      regs.reg_we <= 1'b0;
      frame_err   <= 1'b0;
      mdio_o      <= 1'b0;
      mdio_oe     <= 1'b0;
`ifdef MINIMAC2_MDIO_PREAMBLE_SUPPRESSION_EN
      supp        <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      ones        <= ones_n;
      bit_cnt     <= cnt_n;
      op_hi       <= op_hi_n;
      is_read     <= is_read_n;
      match       <= match_n;
      addr_sr     <= addr_n;
      data_sr     <= data_n;
      re_d        <= regs.reg_re;
      regs.reg_a  <= reg_a_n;
      regs.reg_do <= reg_do_n;
      regs.reg_re <= re_n;
      regs.reg_we <= we_n;
      frame_err   <= err_n;
      mdio_o      <= mdio_o_n;
      mdio_oe     <= mdio_oe_n;
`ifdef MINIMAC2_MDIO_PREAMBLE_SUPPRESSION_EN
      supp        <= supp_n;
`endif
    end
  end
endmodule
